// File: rtl/fork_join_timer.sv
// Fork/join delay timer: launches up to NUM_CH countdown channels and signals
// JOIN_ALL / JOIN_ANY / JOIN_NONE completion. Optional FJT_TIMESTAMP_EN adds ch_ts capture.
module fork_join_timer #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned DLY_W  = 8,
  parameter int unsigned TS_W   = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [NUM_CH-1:0]       ch_en,
  input  logic [NUM_CH*DLY_W-1:0] ch_dly,
  input  logic [1:0]              join_mode,
  input  logic                    kill,
  output logic                    busy,
  output logic [NUM_CH-1:0]       ch_active,
  output logic [NUM_CH-1:0]       ch_done,
  output logic                    join_done
`ifdef FJT_TIMESTAMP_EN
  ,
  output logic [NUM_CH*TS_W-1:0]  ch_ts
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    JOIN_ALL  = 2'b00,
    JOIN_ANY  = 2'b01,
    JOIN_NONE = 2'b10
  } join_e;

  state_e           state;
  join_e            mode;
  logic             join_pend;
  logic [DLY_W-1:0] cnt [NUM_CH];
  logic [NUM_CH-1:0] finishing;
  logic [NUM_CH-1:0] remaining;

`ifdef FJT_TIMESTAMP_EN
  logic [TS_W-1:0]  ts_cnt;
`endif

  // A channel finishes on the edge where its counter is already at zero,
  // which yields D+1 edges from the launch edge.
  always_comb begin
    finishing = '0;
    for (int unsigned i = 0; i < NUM_CH; i++)
      finishing[i] = ch_active[i] && (cnt[i] == '0);
    remaining = ch_active & ~finishing;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      mode      <= JOIN_ALL;
      join_pend <= 1'b0;
      busy      <= 1'b0;
      ch_active <= '0;
      ch_done   <= '0;
      join_done <= 1'b0;
      for (int unsigned i = 0; i < NUM_CH; i++)
        cnt[i] <= '0;
`ifdef FJT_TIMESTAMP_EN
      ts_cnt    <= '0;
      ch_ts     <= '0;
`endif
    end else begin
      ch_done   <= '0;
      join_done <= 1'b0;
`ifdef FJT_TIMESTAMP_EN
      ts_cnt    <= ts_cnt + 1'b1;
`endif
      case (state)
        IDLE: begin
          // An empty launch completes its join on the following edge without leaving IDLE.
          join_done <= join_pend;
          join_pend <= start && !kill && (ch_en == '0);
          if (start && !kill) begin
`ifdef FJT_TIMESTAMP_EN
            ch_ts <= '0;
`endif
            if (ch_en != '0) begin
              for (int unsigned i = 0; i < NUM_CH; i++)
                cnt[i] <= ch_en[i] ? ch_dly[i*DLY_W +: DLY_W] : '0;
              ch_active <= ch_en;
              mode      <= (join_mode == 2'b11) ? JOIN_ALL : join_e'(join_mode);
              busy      <= 1'b1;
              state     <= RUN;
            end
          end
        end
        default: begin
          if (kill) begin
            for (int unsigned i = 0; i < NUM_CH; i++)
              cnt[i] <= '0;
            ch_active <= '0;
            busy      <= 1'b0;
            state     <= IDLE;
          end else begin
            for (int unsigned i = 0; i < NUM_CH; i++)
              if (ch_active[i] && (cnt[i] != '0))
                cnt[i] <= cnt[i] - 1'b1;
            ch_done   <= finishing;
            ch_active <= remaining;
`ifdef FJT_TIMESTAMP_EN
            for (int unsigned i = 0; i < NUM_CH; i++)
              if (finishing[i])
                ch_ts[i*TS_W +: TS_W] <= ts_cnt;
`endif
            if (remaining == '0) begin
              busy  <= 1'b0;
              state <= IDLE;
            end
            if (state == RUN) begin
              case (mode)
                JOIN_ANY: begin
                  if (finishing != '0) begin
                    join_done <= 1'b1;
                    if (remaining != '0)
                      state <= DRAIN;
                  end
                end
                JOIN_NONE: begin
                  join_done <= 1'b1;
                  if (remaining != '0)
                    state <= DRAIN;
                end
                default: begin
                  if (remaining == '0)
                    join_done <= 1'b1;
                end
              endcase
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fork_join_timer.sv
// Self-checking bench for fork_join_timer: per-cycle comparison against a
// launch-time/deadline model, plus literal timing checks per scenario.
module tb_fork_join_timer;
  localparam int NC  = 4;
  localparam int DW  = 8;
  localparam int TW  = 4;
  localparam int INF = 32'h7fffffff;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic kill = 1'b0;
  logic [NC-1:0]    ch_en = '0;
  logic [NC*DW-1:0] ch_dly = '0;
  logic [1:0]       join_mode = '0;
  logic             busy, join_done;
  logic [NC-1:0]    ch_active, ch_done;
`ifdef FJT_TIMESTAMP_EN
  logic [NC*TW-1:0] ch_ts;
  logic [NC*TW-1:0] m_ts;
`endif

  fork_join_timer #(.NUM_CH(NC), .DLY_W(DW), .TS_W(TW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .ch_en(ch_en), .ch_dly(ch_dly),
    .join_mode(join_mode), .kill(kill), .busy(busy), .ch_active(ch_active),
    .ch_done(ch_done), .join_done(join_done)
`ifdef FJT_TIMESTAMP_EN
    , .ch_ts(ch_ts)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Model: a launch is described by its accept edge, enables, delays and kill edge.
  int cyc = 0;
  bit launched = 1'b0;
  int t0 = 0;
  logic [NC-1:0] m_en = '0;
  int m_dly [NC];
  logic [1:0] m_mode = '0;
  int kill_e = INF;
  int ts_n = 0;
  bit bp;

  function automatic int done_at(int i);
    return t0 + m_dly[i] + 1;
  endfunction

  function automatic int max_done();
    int m = t0;
    for (int i = 0; i < NC; i++)
      if (m_en[i] && done_at(i) > m) m = done_at(i);
    return m;
  endfunction

  function automatic int min_done();
    int m = INF;
    for (int i = 0; i < NC; i++)
      if (m_en[i] && done_at(i) < m) m = done_at(i);
    return m;
  endfunction

  function automatic bit m_busy(int e);
    return launched && e >= t0 && e < max_done() && e < kill_e;
  endfunction

  function automatic logic [NC-1:0] m_active(int e);
    logic [NC-1:0] v = '0;
    for (int i = 0; i < NC; i++)
      v[i] = launched && m_en[i] && e >= t0 && e < done_at(i) && e < kill_e;
    return v;
  endfunction

  function automatic logic [NC-1:0] m_done(int e);
    logic [NC-1:0] v = '0;
    for (int i = 0; i < NC; i++)
      v[i] = launched && m_en[i] && e == done_at(i) && e < kill_e;
    return v;
  endfunction

  function automatic bit m_join(int e);
    if (!launched || e >= kill_e) return 1'b0;
    if (m_en == '0 || m_mode == 2'b10) return e == t0 + 1;
    if (m_mode == 2'b01) return e == min_done();
    return e == max_done();
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      launched = 1'b0;
      ts_n = 0;
`ifdef FJT_TIMESTAMP_EN
      m_ts = '0;
`endif
    end else begin
      bp = m_busy(cyc);
      cyc++;
      if (kill && bp) kill_e = cyc;
      else if (start && !kill && !bp) begin
        launched = 1'b1;
        t0 = cyc;
        m_en = ch_en;
        m_mode = join_mode;
        kill_e = INF;
        for (int i = 0; i < NC; i++) m_dly[i] = int'(ch_dly[i*DW +: DW]);
`ifdef FJT_TIMESTAMP_EN
        m_ts = '0;
`endif
      end
`ifdef FJT_TIMESTAMP_EN
      for (int i = 0; i < NC; i++)
        if (m_done(cyc)[i]) m_ts[i*TW +: TW] = TW'(ts_n);
`endif
      ts_n++;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  // Observations relative to the model's current launch edge.
  int obs_done_rel [NC];
  int obs_done_cnt, obs_join_rel, obs_join_cnt, obs_fall;
  bit obs_busy_seen, prev_busy;

  task automatic clear_obs();
    for (int i = 0; i < NC; i++) obs_done_rel[i] = -1;
    obs_done_cnt = 0; obs_join_rel = -1; obs_join_cnt = 0;
    obs_fall = -1; obs_busy_seen = 1'b0;
  endtask

  always @(negedge clk) begin
    chk("busy", 32'(busy), 32'(m_busy(cyc)));
    chk("ch_active", 32'(ch_active), 32'(m_active(cyc)));
    chk("ch_done", 32'(ch_done), 32'(m_done(cyc)));
    chk("join_done", 32'(join_done), 32'(m_join(cyc)));
`ifdef FJT_TIMESTAMP_EN
    chk("ch_ts", 32'(ch_ts), 32'(m_ts));
`endif
    for (int i = 0; i < NC; i++)
      if (ch_done[i]) begin obs_done_rel[i] = cyc - t0; obs_done_cnt++; end
    if (join_done) begin obs_join_rel = cyc - t0; obs_join_cnt++; end
    if (busy) obs_busy_seen = 1'b1;
    if (prev_busy && !busy) obs_fall = cyc - t0;
    prev_busy = busy;
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called at a negedge; start is sampled on the next rising edge.
  task automatic launch(input logic [NC-1:0] en, input int d0, input int d1,
                        input int d2, input int d3, input logic [1:0] mode);
    clear_obs();
    start = 1'b1; ch_en = en; join_mode = mode;
    ch_dly = {DW'(d3), DW'(d2), DW'(d1), DW'(d0)};
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic pulse_kill();
    kill = 1'b1;
    @(negedge clk);
    kill = 1'b0;
  endtask

  initial begin
    clear_obs();
    prev_busy = 1'b0;
    idle(3);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_join", 32'(join_done), 32'd0);
    rst_n = 1'b1;
    idle(2);

    // JOIN_ALL, delays 30/7/10
    launch(4'b0111, 30, 7, 10, 0, 2'b00);
    idle(38);
    chk("all_done1", obs_done_rel[1], 8);
    chk("all_done2", obs_done_rel[2], 11);
    chk("all_done0", obs_done_rel[0], 31);
    chk("all_join", obs_join_rel, 31);
    chk("all_fall", obs_fall, 31);

    // JOIN_ANY, same delays, extra start at +20 must be ignored
    launch(4'b0111, 30, 7, 10, 0, 2'b01);
    idle(19);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    idle(18);
    chk("any_join", obs_join_rel, 8);
    chk("any_join_cnt", obs_join_cnt, 1);
    chk("any_done2", obs_done_rel[2], 11);
    chk("any_done0", obs_done_rel[0], 31);

    // JOIN_NONE
    launch(4'b0011, 5, 1, 0, 0, 2'b10);
    idle(10);
    chk("none_join", obs_join_rel, 1);
    chk("none_done1", obs_done_rel[1], 2);
    chk("none_done0", obs_done_rel[0], 6);
    chk("none_fall", obs_fall, 6);

    // kill mid-run (sampled at +11)
    launch(4'b0011, 20, 20, 0, 0, 2'b00);
    idle(10);
    pulse_kill();
    idle(15);
    chk("kill_done_cnt", obs_done_cnt, 0);
    chk("kill_join_cnt", obs_join_cnt, 0);
    chk("kill_fall", obs_fall, 11);

    // kill on the completion edge
    launch(4'b0011, 20, 20, 0, 0, 2'b00);
    idle(20);
    pulse_kill();
    idle(5);
    chk("kill_edge_done", obs_done_cnt, 0);
    chk("kill_edge_join", obs_join_cnt, 0);

    // empty launch, then kill+start in IDLE
    launch(4'b0000, 0, 0, 0, 0, 2'b00);
    idle(4);
    chk("empty_join", obs_join_rel, 1);
    chk("empty_busy", 32'(obs_busy_seen), 32'd0);
    clear_obs();
    start = 1'b1; kill = 1'b1; ch_en = 4'b0011;
    @(negedge clk);
    start = 1'b0; kill = 1'b0;
    idle(5);
    chk("killstart_join", obs_join_cnt, 0);
    chk("killstart_busy", 32'(obs_busy_seen), 32'd0);

    // zero delay
    launch(4'b0001, 0, 0, 0, 0, 2'b01);
    idle(4);
    chk("zero_done", obs_done_rel[0], 1);
    chk("zero_join", obs_join_rel, 1);

    // mode 11 behaves as JOIN_ALL
    launch(4'b0101, 3, 0, 6, 0, 2'b11);
    idle(10);
    chk("mode3_join", obs_join_rel, 7);

    // back-to-back: restart in the cycle busy has fallen
    launch(4'b0001, 2, 0, 0, 0, 2'b00);
    idle(3);
    launch(4'b0010, 0, 4, 0, 0, 2'b00);
    idle(8);
    chk("b2b_done1", obs_done_rel[1], 5);

    // asynchronous reset mid-run
    launch(4'b0011, 20, 20, 0, 0, 2'b00);
    idle(5);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_active", 32'(ch_active), 32'd0);
    idle(2);
    rst_n = 1'b1;
    idle(2);
    launch(4'b0001, 1, 0, 0, 0, 2'b00);
    idle(5);
    chk("post_rst_done", obs_done_rel[0], 2);
    chk("post_rst_join", obs_join_rel, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout cyc=%0d got=running expected=finished", cyc);
    $fatal(1);
  end

endmodule
